sample_memory_controller: RTL and testbench
===========================================

Name: sample_memory_controller

Overview:
Sequences the shared sample memory between record (deserializer → memory) and playback (memory → serializer) paths. It owns the memory address, the write strobe and the serializer load, and it tracks the recorded length so playback stops at the end of the recorded data. It sits between the user-control pulses, the deserializer/serializer pair, and the single-port synchronous sample RAM.

Parameters:
WORD_LENGTH, 16, sample width in bits
ADDRESS_WIDTH, 17, memory address width
MEMORY_DEPTH, 131072, usable words; must be ≤ 2**ADDRESS_WIDTH and ≥ 2

Ports:
clock_i  input  1  system clock
reset_i  input  1  asynchronous, active-low reset
record_i  input  1  one-cycle pulse, start recording
play_i  input  1  one-cycle pulse, start playback
stop_i  input  1  one-cycle pulse, abort the active operation
deserializer_done_i  input  1  one-cycle pulse, sample_i valid
sample_i  input  WORD_LENGTH  captured sample
serializer_done_i  input  1  one-cycle pulse, serializer has finished the current word
serializer_load_o  output  1  one-cycle pulse, load serializer_data_o
serializer_data_o  output  WORD_LENGTH  word for the serializer
memory_address_o  output  ADDRESS_WIDTH  RAM address
memory_write_enable_o  output  1  RAM write strobe
memory_write_data_o  output  WORD_LENGTH  RAM write data
memory_read_data_i  input  WORD_LENGTH  RAM read data, valid 1 cycle after the address
recorded_length_o  output  ADDRESS_WIDTH+1  number of valid recorded words
mode_o  output  2  0 = idle, 1 = record, 2 = play

Behaviour:
- Reset (reset_i = 0, asynchronous): state IDLE. All outputs are 0, including recorded_length_o and the internal pointer.
- All outputs are registered. The pointer is ADDRESS_WIDTH+1 bits wide. memory_address_o = pointer[ADDRESS_WIDTH-1:0].
- IDLE, priority order record_i > play_i:
  - record_i: pointer ← 0, recorded_length_o ← 0, go to REC_WAIT.
  - play_i with recorded_length_o > 0: pointer ← 0, go to PLAY_ADDR.
  - play_i with recorded_length_o = 0: ignored.
  - stop_i: ignored.
- REC_WAIT:
  - On deserializer_done_i: latch sample_i into memory_write_data_o, go to REC_WRITE.
  - stop_i alone: recorded_length_o ← pointer, go to IDLE.
  - stop_i and deserializer_done_i in the same cycle: the sample is still written, then the block goes to IDLE after the write.
- REC_WRITE (1 cycle): memory_write_enable_o = 1 at the current address. Next cycle: pointer + 1.
  - If pointer + 1 = MEMORY_DEPTH (memory full), or a stop is pending: recorded_length_o ← pointer + 1, go to IDLE.
  - Otherwise go to REC_WAIT.
  - deserializer_done_i arriving during REC_WRITE is dropped. The deserializer period is always ≥ 2 cycles.
- PLAY_ADDR: drive the address, go to PLAY_READ.
- PLAY_READ: RAM latency cycle, go to PLAY_LOAD.
- PLAY_LOAD: register memory_read_data_i into serializer_data_o, pulse serializer_load_o for 1 cycle, go to PLAY_WAIT.
- PLAY_WAIT: on serializer_done_i, pointer + 1.
  - If pointer + 1 = recorded_length_o: go to IDLE, address ← 0.
  - Otherwise go to PLAY_ADDR.
  - Load-to-next-load spacing = serializer period + 3 cycles.
- stop_i in any PLAY_* state: go to IDLE next cycle. Any serializer_load_o is cancelled and the serializer is not reloaded.
- record_i and play_i are ignored outside IDLE.
- serializer_data_o holds its last value in IDLE.
- mode_o: 1 in REC_*, 2 in PLAY_*, 0 in IDLE. It is updated in the same cycle as the state.
- memory_write_enable_o is never asserted outside REC_WRITE.

Optional Feature:
- Macro: LOOP_PLAYBACK_EN.
- Defined: in PLAY_WAIT, when pointer + 1 = recorded_length_o, pointer ← 0 and the block goes to PLAY_ADDR. Playback repeats until stop_i.
- Undefined: playback ends in IDLE after the last word, as described above.

Test Plan:
- Reset mid-REC_WRITE (reset_i low for 1 cycle) → write enable deasserts immediately, all outputs 0, mode_o = 0, recorded_length_o = 0.
- record_i, then 5 deserializer_done_i pulses with samples 0x0001..0x0005, then stop_i → writes at addresses 0..4 with matching data, recorded_length_o = 5, mode_o returns to 0.
- With recorded_length_o = 5, play_i → serializer_load_o pulses with 0x0001..0x0005 in order, each 3 cycles after the previous serializer_done_i. After the 5th done, back in IDLE. With LOOP_PLAYBACK_EN, the 6th load carries 0x0001.
- MEMORY_DEPTH = 4, record 6 samples without stop → exactly 4 writes, recorded_length_o = 4, returns to IDLE automatically, 5th and 6th samples not written.
- record_i and play_i in the same cycle from IDLE → record mode. play_i with recorded_length_o = 0 → mode_o stays 0.
- stop_i coincident with deserializer_done_i → sample written, recorded_length_o includes it. stop_i during PLAY_READ → no serializer_load_o pulse.

Source files
------------

// File: rtl/sample_memory_controller.sv
// sample_memory_controller: sequences the sample RAM between record and playback paths.
// Define LOOP_PLAYBACK_EN to make playback restart from word 0 until stopped.
module sample_memory_controller #(
    parameter int WORD_LENGTH   = 16,
    parameter int ADDRESS_WIDTH = 17,
    parameter int MEMORY_DEPTH  = 131072
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     record_i,
    input  logic                     play_i,
    input  logic                     stop_i,
    input  logic                     deserializer_done_i,
    input  logic [WORD_LENGTH-1:0]   sample_i,
    input  logic                     serializer_done_i,
    output logic                     serializer_load_o,
    output logic [WORD_LENGTH-1:0]   serializer_data_o,
    output logic [ADDRESS_WIDTH-1:0] memory_address_o,
    output logic                     memory_write_enable_o,
    output logic [WORD_LENGTH-1:0]   memory_write_data_o,
    input  logic [WORD_LENGTH-1:0]   memory_read_data_i,
    output logic [ADDRESS_WIDTH:0]   recorded_length_o,
    output logic [1:0]               mode_o
);
    typedef enum logic [2:0] {IDLE, REC_WAIT, REC_WRITE, PLAY_ADDR, PLAY_READ, PLAY_LOAD, PLAY_WAIT} state_t;
    localparam logic [ADDRESS_WIDTH:0] DEPTH = (ADDRESS_WIDTH+1)'(MEMORY_DEPTH);
    state_t state, state_next;
    logic [ADDRESS_WIDTH:0] pointer, pointer_next, pointer_inc, length_next;
    logic stop_pending, stop_pending_next;
    logic playing;
    assign pointer_inc = pointer + (ADDRESS_WIDTH+1)'(1);
    assign memory_address_o = pointer[ADDRESS_WIDTH-1:0];
    assign playing = state inside {PLAY_ADDR, PLAY_READ, PLAY_LOAD, PLAY_WAIT};
    always_comb begin
        state_next = state;
        pointer_next = pointer;
        length_next = recorded_length_o;
        stop_pending_next = stop_pending;
        case (state)
            IDLE:
                if (record_i) begin
                    pointer_next = '0;
                    length_next = '0;
                    stop_pending_next = 1'b0;
                    state_next = REC_WAIT;
                end else if (play_i && recorded_length_o != '0) begin
                    pointer_next = '0;
                    state_next = PLAY_ADDR;
                end
            REC_WAIT:
                if (deserializer_done_i) begin
                    stop_pending_next = stop_i;
                    state_next = REC_WRITE;
                end else if (stop_i) begin
                    length_next = pointer;
                    state_next = IDLE;
                end
            REC_WRITE: begin
                pointer_next = pointer_inc;
                if (pointer_inc == DEPTH || stop_pending || stop_i) begin
                    length_next = pointer_inc;
                    state_next = IDLE;
                end else
                    state_next = REC_WAIT;
            end
            PLAY_ADDR: state_next = PLAY_READ;
            PLAY_READ: state_next = PLAY_LOAD;
            PLAY_LOAD: state_next = PLAY_WAIT;
            PLAY_WAIT:
                if (serializer_done_i) begin
                    pointer_next = pointer_inc == recorded_length_o ? '0 : pointer_inc;
`ifdef LOOP_PLAYBACK_EN
                    state_next = PLAY_ADDR;
`else
                    state_next = pointer_inc == recorded_length_o ? IDLE : PLAY_ADDR;
`endif
                end
            default: state_next = IDLE;
        endcase
        // a stop during playback pre-empts any load that was about to be issued
        if (playing && stop_i) state_next = IDLE;
    end
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
            pointer <= '0;
            recorded_length_o <= '0;
            stop_pending <= 1'b0;
            memory_write_enable_o <= 1'b0;
            memory_write_data_o <= '0;
            serializer_load_o <= 1'b0;
            serializer_data_o <= '0;
            mode_o <= 2'd0;
        end else begin
            state <= state_next;
            pointer <= pointer_next;
            recorded_length_o <= length_next;
            stop_pending <= stop_pending_next;
            memory_write_enable_o <= state_next == REC_WRITE;
            if (state == REC_WAIT && deserializer_done_i) memory_write_data_o <= sample_i;
            serializer_load_o <= state_next == PLAY_LOAD;
            if (state_next == PLAY_LOAD) serializer_data_o <= memory_read_data_i;
            mode_o <= state_next inside {REC_WAIT, REC_WRITE} ? 2'd1 :
                      state_next inside {PLAY_ADDR, PLAY_READ, PLAY_LOAD, PLAY_WAIT} ? 2'd2 : 2'd0;
        end
    end
endmodule

// File: tb/tb_sample_memory_controller.sv
// tb_sample_memory_controller: randomized record/playback against a queue-based model of the recorded data.
module tb_sample_memory_controller;
    localparam int W = 16;
    localparam int AW = 3;
    localparam int DEPTH = 8;

    logic clock_i = 1'b0;
    logic reset_i = 1'b0;
    logic record_i = 1'b0;
    logic play_i = 1'b0;
    logic stop_i = 1'b0;
    logic deserializer_done_i = 1'b0;
    logic serializer_done_i = 1'b0;
    logic [W-1:0] sample_i = '0;
    logic [W-1:0] memory_read_data_i;
    logic serializer_load_o;
    logic [W-1:0] serializer_data_o;
    logic [AW-1:0] memory_address_o;
    logic memory_write_enable_o;
    logic [W-1:0] memory_write_data_o;
    logic [AW:0] recorded_length_o;
    logic [1:0] mode_o;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int load_count = 0;
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rec [$];
    int wr_addr_q [$];
    logic [W-1:0] wr_data_q [$];

    sample_memory_controller #(.WORD_LENGTH(W), .ADDRESS_WIDTH(AW), .MEMORY_DEPTH(DEPTH)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .record_i(record_i), .play_i(play_i), .stop_i(stop_i),
        .deserializer_done_i(deserializer_done_i), .sample_i(sample_i),
        .serializer_done_i(serializer_done_i), .serializer_load_o(serializer_load_o),
        .serializer_data_o(serializer_data_o), .memory_address_o(memory_address_o),
        .memory_write_enable_o(memory_write_enable_o), .memory_write_data_o(memory_write_data_o),
        .memory_read_data_i(memory_read_data_i), .recorded_length_o(recorded_length_o), .mode_o(mode_o)
    );

    always #5 clock_i = ~clock_i;
    always @(posedge clock_i) cyc <= cyc + 1;

    // single-port synchronous RAM, read data valid one cycle after the address
    always @(posedge clock_i) begin
        if (memory_write_enable_o) mem[memory_address_o] <= memory_write_data_o;
        memory_read_data_i <= mem[memory_address_o];
    end

    always @(negedge clock_i) begin
        if (memory_write_enable_o) begin
            wr_addr_q.push_back(int'(memory_address_o));
            wr_data_q.push_back(memory_write_data_o);
        end
        if (serializer_load_o) load_count++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    // kind: 0 = stop after the last sample, 1 = stop with the last sample, 2 = no stop
    task automatic record_run(input int n, input int kind, input bit directed);
        int exp_n;
        logic [W-1:0] s;
        exp_n = n < DEPTH ? n : DEPTH;
        wr_addr_q.delete();
        wr_data_q.delete();
        rec.delete();
        step(); record_i = 1'b1;
        step(); record_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(1, 3)) step();
            s = directed ? W'(i + 1) : W'($urandom);
            if (i < DEPTH) rec.push_back(s);
            sample_i = s;
            deserializer_done_i = 1'b1;
            stop_i = kind == 1 && i == n - 1;
            step();
            deserializer_done_i = 1'b0;
            stop_i = 1'b0;
        end
        repeat (3) step();
        if (kind == 0) begin
            stop_i = 1'b1;
            step();
            stop_i = 1'b0;
        end
        repeat (2) step();
        chk("rec_mode_idle", mode_o, 0);
        chk("rec_length", recorded_length_o, exp_n);
        chk("rec_write_count", wr_addr_q.size(), exp_n);
        for (int i = 0; i < exp_n && i < wr_addr_q.size(); i++) begin
            chk("rec_write_addr", wr_addr_q[i], i);
            chk("rec_write_data", wr_data_q[i], rec[i]);
        end
    endtask

    task automatic play_run(input int len);
        int base;
        int dcyc;
        bit seen;
        base = load_count;
        dcyc = 0;
        step(); play_i = 1'b1;
        step(); play_i = 1'b0;
        for (int k = 0; k < len; k++) begin
            seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                step();
                seen = serializer_load_o;
            end
            chk("load_seen", seen, 1);
            if (!seen) return;
            chk("load_data", serializer_data_o, rec[k]);
            if (k > 0) chk("load_gap", cyc - dcyc, 3);
            repeat ($urandom_range(1, 4)) step();
            serializer_done_i = 1'b1;
            dcyc = cyc;
            step();
            serializer_done_i = 1'b0;
        end
`ifdef LOOP_PLAYBACK_EN
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            step();
            seen = serializer_load_o;
        end
        chk("loop_load_seen", seen, 1);
        chk("loop_load_data", serializer_data_o, rec[0]);
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        step();
        chk("loop_stop_idle", mode_o, 0);
`else
        repeat (5) step();
        chk("play_end_idle", mode_o, 0);
        chk("play_load_count", load_count - base, len);
        chk("play_end_addr", memory_address_o, 0);
`endif
    endtask

    initial begin
        int base;
        repeat (2) step();
        chk("rst_mode", mode_o, 0);
        chk("rst_we", memory_write_enable_o, 0);
        chk("rst_load", serializer_load_o, 0);
        chk("rst_length", recorded_length_o, 0);
        chk("rst_addr", memory_address_o, 0);
        chk("rst_wdata", memory_write_data_o, 0);
        chk("rst_sdata", serializer_data_o, 0);
        reset_i = 1'b1;

        step(); record_i = 1'b1; play_i = 1'b1;
        step(); record_i = 1'b0; play_i = 1'b0;
        chk("record_over_play", mode_o, 1);
        stop_i = 1'b1;
        step(); stop_i = 1'b0;
        step();
        chk("empty_stop_mode", mode_o, 0);
        chk("empty_stop_length", recorded_length_o, 0);
        play_i = 1'b1;
        step(); play_i = 1'b0;
        step();
        chk("play_empty_ignored", mode_o, 0);

        record_run(5, 0, 1'b1);
        play_run(5);
        record_run($urandom_range(2, 6), 1, 1'b0);
        play_run(rec.size());
        record_run(DEPTH + 2, 2, 1'b0);
        play_run(DEPTH);

        base = load_count;
        step(); play_i = 1'b1;
        step(); play_i = 1'b0;
        step(); stop_i = 1'b1;
        step(); stop_i = 1'b0;
        repeat (5) step();
        chk("stop_read_idle", mode_o, 0);
        chk("stop_read_no_load", load_count - base, 0);

        step(); record_i = 1'b1;
        step(); record_i = 1'b0;
        step(); sample_i = 16'hABCD; deserializer_done_i = 1'b1;
        step(); deserializer_done_i = 1'b0;
        chk("we_in_write", memory_write_enable_o, 1);
        #2 reset_i = 1'b0;
        #1;
        chk("arst_we", memory_write_enable_o, 0);
        chk("arst_mode", mode_o, 0);
        chk("arst_length", recorded_length_o, 0);
        chk("arst_addr", memory_address_o, 0);
        chk("arst_wdata", memory_write_data_o, 0);
        #1 reset_i = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
